// File: rtl/adder_pkg.sv
// Shared types and the prefix operator for the adder/subtractor prefix networks.
package adder_pkg;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  localparam int ADD_WIDTH = 8;
  localparam int ADD_SPLIT = 4;

  // Combines a higher-order span (hi) with the adjacent lower span (lo).
  function automatic pg_t pg_combine(input pg_t hi, input pg_t lo);
    pg_t r;
    r.p = hi.p & lo.p;
    r.g = hi.g | (hi.p & lo.g);
    return r;
  endfunction

endpackage

// File: rtl/sub8_pipe_if.sv
// Operand/result stream bundle for sub8_pipe: valid/ready in, valid/ready out.
interface sub8_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, diff, borrow, ovf, zero
  );

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, diff, borrow, ovf, zero
  );
endinterface

// File: rtl/sub8_prefix_half.sv
// Kogge-Stone carry network over N bits with an external carry-in.
// Returns carries into bit positions 1..N.
module sub8_prefix_half
  import adder_pkg::*;
#(
  parameter int N = 4
) (
  input  pg_t [N-1:0] pg_i,
  input  logic        cin_i,
  output logic [N:1]  carry_o
);
  localparam int LEVELS = $clog2(N);

  pg_t [LEVELS:0][N-1:0] lvl;

  genvar gi, gl;
  generate
    for (gi = 0; gi < N; gi++) begin : g_seed
      assign lvl[0][gi] = pg_i[gi];
    end

    for (gl = 0; gl < LEVELS; gl++) begin : g_level
      for (gi = 0; gi < N; gi++) begin : g_node
        if (gi >= (1 << gl)) begin : g_comb
          assign lvl[gl+1][gi] = pg_combine(lvl[gl][gi], lvl[gl][gi-(1<<gl)]);
        end else begin : g_pass
          assign lvl[gl+1][gi] = lvl[gl][gi];
        end
      end
    end

    // Group (G,P) spanning [gi:0] folds in the carry-in as the final step.
    for (gi = 0; gi < N; gi++) begin : g_carry
      assign carry_o[gi+1] = lvl[LEVELS][gi].g | (lvl[LEVELS][gi].p & cin_i);
    end
  endgenerate

endmodule

// File: rtl/sub8_pipe.sv
// Two-stage pipelined subtractor (a + ~b + 1) with an elastic valid/ready stream.
// Low half of the carry chain resolves in stage 1, high half in stage 2.
module sub8_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH,
  parameter int SPLIT = ADD_SPLIT
) (
  input  logic        clk,
  input  logic        rst_n,
  sub8_pipe_if.slave  bus
);
  localparam int HI = WIDTH - SPLIT;

  // Handshake
  logic init_q;
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s2_load, s1_adv, in_ready, in_fire;

  assign s2_load  = !s2_valid_q || bus.out_ready;
  assign s1_adv   = s1_valid_q && s2_load;
  assign in_ready = init_q && (!s1_valid_q || !s2_valid_q || bus.out_ready);
  assign in_fire  = bus.in_valid && in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
    s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      init_q     <= 1'b1;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  // Stage 1: propagate/generate of a + ~b, low-half carries with cin = 1
  pg_t [WIDTH-1:0] pg_in;
  logic [SPLIT:1]  c_lo;
  logic [SPLIT-1:0] c_lo_in;
  logic [SPLIT-1:0] diff_lo_d;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_pg
      assign pg_in[gi].p = bus.a_in[gi] ^ ~bus.b_in[gi];
      assign pg_in[gi].g = bus.a_in[gi] & ~bus.b_in[gi];
    end
  endgenerate

  sub8_prefix_half #(.N(SPLIT)) u_prefix_lo (
    .pg_i    (pg_in[SPLIT-1:0]),
    .cin_i   (1'b1),
    .carry_o (c_lo)
  );

  assign c_lo_in = {c_lo[SPLIT-1:1], 1'b1};

  generate
    for (gi = 0; gi < SPLIT; gi++) begin : g_diff_lo
      assign diff_lo_d[gi] = pg_in[gi].p ^ c_lo_in[gi];
    end
  endgenerate

  // Stage-1 data needs no reset: it is only observed behind s1_valid_q.
  logic [SPLIT-1:0] s1_diff_lo_q;
  logic             s1_c_q;
  pg_t [HI-1:0]     s1_pg_hi_q;
  logic             s1_a_msb_q;
  logic             s1_b_msb_q;

  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_diff_lo_q <= diff_lo_d;
      s1_c_q       <= c_lo[SPLIT];
      s1_pg_hi_q   <= pg_in[WIDTH-1:SPLIT];
      s1_a_msb_q   <= bus.a_in[WIDTH-1];
      s1_b_msb_q   <= bus.b_in[WIDTH-1];
    end
  end

  // Stage 2: high-half carries seeded by the registered mid carry
  logic [HI:1]      c_hi;
  logic [HI-1:0]    c_hi_in;
  logic [HI-1:0]    diff_hi_d;
  logic [WIDTH-1:0] diff_d;
  logic             borrow_d, ovf_d, zero_d;

  sub8_prefix_half #(.N(HI)) u_prefix_hi (
    .pg_i    (s1_pg_hi_q),
    .cin_i   (s1_c_q),
    .carry_o (c_hi)
  );

  assign c_hi_in = {c_hi[HI-1:1], s1_c_q};

  generate
    for (gi = 0; gi < HI; gi++) begin : g_diff_hi
      assign diff_hi_d[gi] = s1_pg_hi_q[gi].p ^ c_hi_in[gi];
    end
  endgenerate

  assign diff_d   = {diff_hi_d, s1_diff_lo_q};
  assign borrow_d = ~c_hi[HI];
  assign ovf_d    = (s1_a_msb_q != s1_b_msb_q) && (diff_d[WIDTH-1] != s1_a_msb_q);
  assign zero_d   = (diff_d == '0);

  logic [WIDTH-1:0] diff_q;
  logic             borrow_q, ovf_q, zero_q;

  // Result registers only move when a new result replaces an empty or draining slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else if (s2_load && s1_valid_q) begin
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid_q;
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_sub8_pipe.sv
// Directed + streaming bench for sub8_pipe; one line per failed comparison, one summary line.
module tb_sub8_pipe;

  typedef struct packed {
    logic [7:0] diff;
    logic       borrow;
    logic       ovf;
    logic       zero;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sub8_pipe_if #(.WIDTH(8)) bus ();

  sub8_pipe #(.WIDTH(8), .SPLIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks = 0;
  int   failures = 0;
  res_t exp_q[$];
  logic stall_prev = 1'b0;
  res_t stall_val;

  function automatic res_t mk(input logic [7:0] d, input logic b, input logic o, input logic z);
    res_t r;
    r.diff = d; r.borrow = b; r.ovf = o; r.zero = z;
    return r;
  endfunction

  function automatic res_t model(input logic [7:0] a, input logic [7:0] b);
    res_t r;
    r.diff   = a - b;
    r.borrow = (a < b);
    r.ovf    = (a[7] != b[7]) && (r.diff[7] != a[7]);
    r.zero   = (r.diff == 8'h00);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic res_t outs();
    res_t r;
    r.diff = bus.diff; r.borrow = bus.borrow; r.ovf = bus.ovf; r.zero = bus.zero;
    return r;
  endfunction

  // One clock: drive just after negedge, evaluate handshakes 1ns later, end on next negedge.
  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic rdy, input res_t e, output logic acc);
    res_t obs;
    bus.in_valid  = v;
    bus.a_in      = a;
    bus.b_in      = b;
    bus.out_ready = rdy;
    #1;
    obs = outs();
    if (stall_prev) begin
      chk("stall_hold", 16'(obs), 16'(stall_val));
      chk("stall_valid", 16'(bus.out_valid), 16'd1);
    end
    chk("in_ready", 16'(bus.in_ready), 16'(!(exp_q.size() == 2 && !rdy)));
    if (bus.out_valid) begin
      if (exp_q.size() == 0) chk("spurious_valid", 16'(bus.out_valid), 16'd0);
      else if (rdy) chk("result", 16'(obs), 16'(exp_q.pop_front()));
    end
    stall_prev = bus.out_valid && !rdy;
    stall_val  = obs;
    acc = v && bus.in_ready;
    if (acc) exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) step(1'b0, 8'h00, 8'h00, 1'b1, '0, acc);
    chk("drain_empty", 16'(exp_q.size()), 16'd0);
  endtask

  initial begin
    logic       acc;
    logic       pend;
    logic       rv;
    logic [7:0] ra, rb;

    bus.in_valid = 1'b0; bus.a_in = 8'h00; bus.b_in = 8'h00; bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
    chk("rst_outs", 16'(outs()), 16'd0);
    chk("rst_in_ready", 16'(bus.in_ready), 16'd0);
    rst_n = 1'b1;
    #1;
    chk("release_in_ready_early", 16'(bus.in_ready), 16'd0);
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    chk("release_in_ready", 16'(bus.in_ready), 16'd1);
    @(negedge clk);

    // 1: latency and first result
    step(1'b1, 8'h05, 8'h03, 1'b1, mk(8'h02, 1'b0, 1'b0, 1'b0), acc);
    chk("lat1_valid", 16'(bus.out_valid), 16'd0);
    step(1'b0, 8'h00, 8'h00, 1'b1, '0, acc);
    chk("lat2_valid", 16'(bus.out_valid), 16'd1);
    drain();

    // 2-3: wrap, equality and signed edges, back to back
    step(1'b1, 8'h00, 8'h01, 1'b1, mk(8'hFF, 1'b1, 1'b0, 1'b0), acc);
    step(1'b1, 8'h3C, 8'h3C, 1'b1, mk(8'h00, 1'b0, 1'b0, 1'b1), acc);
    step(1'b1, 8'h80, 8'h01, 1'b1, mk(8'h7F, 1'b0, 1'b1, 1'b0), acc);
    step(1'b1, 8'h7F, 8'hFF, 1'b1, mk(8'h80, 1'b1, 1'b1, 1'b0), acc);
    step(1'b1, 8'hFF, 8'h00, 1'b1, mk(8'hFF, 1'b0, 1'b0, 1'b0), acc);
    step(1'b1, 8'h00, 8'h80, 1'b1, mk(8'h80, 1'b1, 1'b1, 1'b0), acc);
    drain();

    // 4: full-rate random stream
    for (int i = 0; i < 256; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      step(1'b1, ra, rb, 1'b1, model(ra, rb), acc);
      if (i > 0) chk("stream_accept", 16'(acc), 16'd1);
    end
    drain();

    // 5: random backpressure with held operands while not accepted
    pend = 1'b0; rv = 1'b0; ra = 8'h00; rb = 8'h00;
    for (int i = 0; i < 600; i++) begin
      if (!pend) begin
        ra = 8'($urandom);
        rb = 8'($urandom);
        rv = ($urandom_range(0, 3) != 0);
      end
      step(rv, ra, rb, 1'($urandom_range(0, 1)), model(ra, rb), acc);
      pend = rv && !acc;
    end
    drain();

    // 6: reset with two results in flight
    step(1'b1, 8'hAA, 8'h55, 1'b0, model(8'hAA, 8'h55), acc);
    step(1'b1, 8'h12, 8'h34, 1'b0, model(8'h12, 8'h34), acc);
    step(1'b1, 8'h99, 8'h11, 1'b0, model(8'h99, 8'h11), acc);
    chk("full_no_accept", 16'(acc), 16'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 16'(bus.out_valid), 16'd0);
    chk("midrst_outs", 16'(outs()), 16'd0);
    exp_q.delete();
    stall_prev = 1'b0;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", 16'(bus.out_valid), 16'd0);
    step(1'b1, 8'h10, 8'h01, 1'b1, mk(8'h0F, 1'b0, 1'b0, 1'b0), acc);
    chk("post_rst_accept", 16'(acc), 16'd1);
    step(1'b0, 8'h00, 8'h00, 1'b1, '0, acc);
    chk("post_rst_valid", 16'(bus.out_valid), 16'd1);
    drain();

    // Exhaustive sweep at full rate
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        step(1'b1, 8'(a), 8'(b), 1'b1, model(8'(a), 8'(b)), acc);
      end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
